// File: rtl/cha_cmd_sequencer.sv
// Command-side initiator for the counter/hold/add datapath: runs a count phase,
// a hold phase, then streams handshaked add operations and returns each result.
module cha_cmd_sequencer #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned DOUT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  count_len,
    input  logic [LEN_W-1:0]  hold_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic              op_last,
    output logic [1:0]        sel,
    output logic [OP_W-1:0]   a,
    output logic [OP_W-1:0]   b,
    input  logic [DOUT_W-1:0] dout,
    output logic [DOUT_W-1:0] res_data,
    output logic              res_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HOLD, S_ADD_REQ, S_ADD_ISSUE, S_ADD_CAPT, S_DONE
    } state_e;

    localparam logic [1:0] SEL_COUNT = 2'b00;
    localparam logic [1:0] SEL_HOLD  = 2'b01;
    localparam logic [1:0] SEL_ADD   = 2'b10;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   hold_len_q, hold_len_d;
    logic               last_q, last_d;
    logic [1:0]         sel_q, sel_d;
    logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
    logic               op_ready_q, op_ready_d;
    logic [DOUT_W-1:0]  res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_len_q  <= '0;
            last_q      <= 1'b0;
            sel_q       <= SEL_HOLD;
            a_q         <= '0;
            b_q         <= '0;
            op_ready_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_len_q  <= hold_len_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_ready_q  <= op_ready_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic; phase counters count remaining cycles minus one
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_len_d  = hold_len_q;
        last_d      = last_q;
        sel_d       = sel_q;
        a_d         = a_q;
        b_d         = b_q;
        op_ready_d  = op_ready_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                sel_d = SEL_HOLD;
                if (start) begin
                    busy_d     = 1'b1;
                    hold_len_d = hold_len;
                    if (count_len != '0) begin
                        state_d = S_COUNT;
                        sel_d   = SEL_COUNT;
                        cnt_d   = count_len - LEN_W'(1);
                    end else if (hold_len != '0) begin
                        state_d = S_HOLD;
                        cnt_d   = hold_len - LEN_W'(1);
                    end else begin
                        state_d    = S_ADD_REQ;
                        op_ready_d = 1'b1;
                    end
                end
            end
            S_COUNT: begin
                if (cnt_q == '0) begin
                    sel_d = SEL_HOLD;
                    if (hold_len_q != '0) begin
                        state_d = S_HOLD;
                        cnt_d   = hold_len_q - LEN_W'(1);
                    end else begin
                        state_d    = S_ADD_REQ;
                        op_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d    = S_ADD_REQ;
                    op_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            S_ADD_REQ: begin
                if (op_valid && op_ready_q) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    last_d     = op_last;
                    sel_d      = SEL_ADD;
                    op_ready_d = 1'b0;
                    state_d    = S_ADD_ISSUE;
                end
            end
            S_ADD_ISSUE: begin
                sel_d   = SEL_HOLD;
                state_d = S_ADD_CAPT;
            end
            S_ADD_CAPT: begin
                res_data_d  = dout;
                res_valid_d = 1'b1;
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_ADD_REQ;
                    op_ready_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                sel_d   = SEL_HOLD;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel       = sel_q;
    assign a         = a_q;
    assign b         = b_q;
    assign op_ready  = op_ready_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cha_cmd_sequencer.sv
// Bench for cha_cmd_sequencer: directed jobs against a counter/hold/add datapath
// model, with results checked by a scoreboard monitor.
module tb_cha_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] count_len, hold_len;
    logic       op_valid, op_ready, op_last;
    logic [2:0] op_a, op_b, a, b;
    logic [1:0] sel;
    logic [3:0] dout, res_data;
    logic       res_valid, busy, done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_res_cyc = -100;
    int exp_q[$];
    int hs_q[$];

    cha_cmd_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .count_len(count_len), .hold_len(hold_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_last(op_last),
        .sel(sel), .a(a), .b(b), .dout(dout), .res_data(res_data), .res_valid(res_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Datapath model: sel 00 counts, 01 holds, 10 loads a+b
    logic [3:0] dp_q;
    always @(posedge clk) begin
        if (rst) dp_q <= '0;
        else if (sel == 2'b00) dp_q <= dp_q + 4'd1;
        else if (sel == 2'b10) dp_q <= 4'(a) + 4'(b);
    end
    assign dout = dp_q;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: tracks handshakes and pops expected results on res_valid
    always @(negedge clk) begin
        if (rst) hs_q.delete();
        else if (op_valid && op_ready) hs_q.push_back(cyc + 1);
        if (res_valid === 1'b1) begin
            last_res_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_res_valid: got res_data %0d with no expected result (cycle %0d)",
                         res_data, cyc);
            end else begin
                check("res_data", int'(res_data), exp_q.pop_front());
                if (hs_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL res_latency: got result with no handshake seen (cycle %0d)", cyc);
                end else begin
                    check("res_latency", cyc, hs_q.pop_front() + 2);
                end
            end
        end
    end

    task automatic do_op(input logic [2:0] oa, input logic [2:0] ob, input logic ol,
                         input int exp, input bit push, input bit keep_valid);
        int n = 0;
        op_a = oa; op_b = ob; op_last = ol; op_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        while (!op_ready && n < 50) begin tick(); n++; end
        check("handshake_ready", int'(op_ready), 1);
        tick();
        check("issue_sel", int'(sel), 2);
        if (!keep_valid) op_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        check("done_seen", int'(done), 1);
        check("done_after_res", cyc, last_res_cyc + 1);
        check("busy_at_done", int'(busy), 0);
    endtask

    task automatic start_job(input logic [3:0] cl, input logic [3:0] hl);
        count_len = cl; hold_len = hl; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; count_len = '0; hold_len = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; op_last = 1'b0;

        // 1: reset values
        tick();
        check("rst_sel", int'(sel), 1);
        check("rst_a", int'(a), 0);
        check("rst_b", int'(b), 0);
        check("rst_op_ready", int'(op_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        tick();
        rst = 1'b0;
        tick();

        // 2: count 10, hold 2
        start_job(4'd10, 4'd2);
        n = 0;
        while (sel == 2'b00 && n < 40) begin n++; tick(); end
        check("count_cycles", n, 10);
        n = 0;
        while (!op_ready && n < 40) begin
            check("hold_sel", int'(sel), 1);
            n++; tick();
        end
        check("hold_cycles", n, 2);
        check("req_sel", int'(sel), 1);
        check("dout_after_count", int'(dout), 10);

        // 3: two ops back to back, op_valid held high
        do_op(3'd1, 3'd3, 1'b0, 4, 1'b1, 1'b1);
        tick();
        check("issue_one_cycle", int'(sel), 1);
        do_op(3'd5, 3'd4, 1'b1, 9, 1'b1, 1'b0);
        wait_done();

        // 4: zero-length phases, then count 15 only
        tick();
        start_job(4'd0, 4'd0);
        check("zero_len_ready", int'(op_ready), 1);
        check("zero_len_sel", int'(sel), 1);
        do_op(3'd2, 3'd3, 1'b1, 5, 1'b1, 1'b0);
        wait_done();
        tick();
        start_job(4'd15, 4'd0);
        n = 0;
        while (sel == 2'b00 && n < 40) begin n++; tick(); end
        check("count15_cycles", n, 15);
        check("count15_ready", int'(op_ready), 1);

        // 5: stall in ADD_REQ while pulsing start
        count_len = 4'd7; hold_len = 4'd7;
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            tick();
            check("stall_sel", int'(sel), 1);
            check("stall_ready", int'(op_ready), 1);
            check("stall_busy", int'(busy), 1);
        end
        start = 1'b0;
        do_op(3'd6, 3'd1, 1'b1, 7, 1'b1, 1'b0);
        wait_done();

        // 6: reset during ADD_ISSUE discards the op
        tick();
        start_job(4'd0, 4'd0);
        do_op(3'd3, 3'd3, 1'b1, 0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_rst_sel", int'(sel), 1);
        check("midop_rst_busy", int'(busy), 0);
        check("midop_rst_ready", int'(op_ready), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midop_no_done", int'(done), 0);
        end
        start_job(4'd1, 4'd1);
        check("c1_sel", int'(sel), 0);
        tick();
        check("h1_sel", int'(sel), 1);
        do_op(3'd2, 3'd2, 1'b1, 4, 1'b1, 1'b0);
        wait_done();

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
